// File: rtl/example_mul_share_arb.sv
// Round-robin arbiter sharing one pipelined signed x unsigned multiplier among NUM_REQ requesters.
// Results leave in order on a single tagged response channel with backpressure.
module example_mul_share_arb #(
    parameter int NUM_REQ    = 4,
    parameter int A_WIDTH    = 14,
    parameter int B_WIDTH    = 9,
    parameter int P_WIDTH    = 21,
    parameter int MUL_STAGES = 2,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [P_WIDTH-1:0]           resp_p,
    output logic [ID_W-1:0]              resp_id,
    output logic [ID_W+1:0]              in_flight
);

    localparam int FULL_W = A_WIDTH + B_WIDTH + 1;

    logic                       adv;
    logic                       granted;
    logic [ID_W-1:0]            grantIdx;
    logic [NUM_REQ-1:0]         grant;
    logic [ID_W-1:0]            rrPtr_q, rrPtr_d;
    logic [ID_W+1:0]            inFlight_q, inFlight_d;
    logic signed [A_WIDTH-1:0]  selA;
    logic [B_WIDTH-1:0]         selB;
    logic signed [FULL_W-1:0]   fullProd;

    logic [MUL_STAGES-1:0]      vld_q;
    logic [P_WIDTH-1:0]         prod_q [MUL_STAGES];
    logic [ID_W-1:0]            id_q   [MUL_STAGES];

    // The whole pipeline moves as one; a stalled output freezes every stage.
    assign resp_valid = vld_q[MUL_STAGES-1];
    assign resp_p     = prod_q[MUL_STAGES-1];
    assign resp_id    = id_q[MUL_STAGES-1];
    assign in_flight  = inFlight_q;
    assign adv        = !resp_valid || resp_ready;
    assign req_ready  = grant;

    always_comb begin
        granted  = 1'b0;
        grantIdx = '0;
        if (adv && !ap_rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!granted && req_valid[(int'(rrPtr_q) + k) % NUM_REQ]) begin
                    granted  = 1'b1;
                    grantIdx = ID_W'((int'(rrPtr_q) + k) % NUM_REQ);
                end
            end
        end
        grant = NUM_REQ'(granted) << grantIdx;
    end

    always_comb begin
        selA = '0;
        selB = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                selA = req_a[k*A_WIDTH +: A_WIDTH];
                selB = req_b[k*B_WIDTH +: B_WIDTH];
            end
        end
    end

    // B is zero-extended so it stays non-negative in the signed multiply.
    assign fullProd = FULL_W'(selA) * FULL_W'($signed({1'b0, selB}));

    always_comb begin
        rrPtr_d    = granted ? ID_W'((int'(grantIdx) + 1) % NUM_REQ) : rrPtr_q;
        inFlight_d = inFlight_q;
        case ({granted, resp_valid && resp_ready})
            2'b10:   inFlight_d = inFlight_q + (ID_W+2)'(1);
            2'b01:   inFlight_d = inFlight_q - (ID_W+2)'(1);
            default: inFlight_d = inFlight_q;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            vld_q      <= '0;
            rrPtr_q    <= '0;
            inFlight_q <= '0;
            for (int k = 0; k < MUL_STAGES; k++) begin
                prod_q[k] <= '0;
                id_q[k]   <= '0;
            end
        end else begin
            rrPtr_q    <= rrPtr_d;
            inFlight_q <= inFlight_d;
            if (adv) begin
                vld_q[0]  <= granted;
                prod_q[0] <= fullProd[P_WIDTH-1:0];
                id_q[0]   <= grantIdx;
                for (int k = 1; k < MUL_STAGES; k++) begin
                    vld_q[k]  <= vld_q[k-1];
                    prod_q[k] <= prod_q[k-1];
                    id_q[k]   <= id_q[k-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_example_mul_share_arb.sv
// Bench for example_mul_share_arb: directed steps plus random traffic against a queue-based
// model of arbitration order, latency and wrapped products.
module tb_example_mul_share_arb;

    localparam int NUM_REQ    = 4;
    localparam int A_WIDTH    = 14;
    localparam int B_WIDTH    = 9;
    localparam int P_WIDTH    = 21;
    localparam int MUL_STAGES = 2;
    localparam int ID_W       = $clog2(NUM_REQ);

    logic                       ap_clk = 1'b0;
    logic                       ap_rst;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*A_WIDTH-1:0] req_a;
    logic [NUM_REQ*B_WIDTH-1:0] req_b;
    logic                       resp_valid;
    logic                       resp_ready;
    logic [P_WIDTH-1:0]         resp_p;
    logic [ID_W-1:0]            resp_id;
    logic [ID_W+1:0]            in_flight;

    int checks   = 0;
    int failures = 0;
    int aVal [NUM_REQ];
    int bVal [NUM_REQ];

    // Model: ordered list of accepted ops, each aging one step per advancing cycle.
    int                 ptrM;
    int                 idQ  [$];
    int                 ageQ [$];
    logic [P_WIDTH-1:0] pQ   [$];

    logic               sampValid;
    logic [P_WIDTH-1:0] sampP;
    logic [ID_W-1:0]    sampId;
    logic [NUM_REQ-1:0] sampReady;
    logic [ID_W+1:0]    sampFlight;
    logic [NUM_REQ-1:0] grantLog [6];
    logic [P_WIDTH-1:0] holdP;
    logic [ID_W-1:0]    holdId;
    logic [ID_W+1:0]    holdFlight;

    example_mul_share_arb #(
        .NUM_REQ(NUM_REQ), .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH),
        .P_WIDTH(P_WIDTH), .MUL_STAGES(MUL_STAGES)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_p(resp_p), .resp_id(resp_id), .in_flight(in_flight)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [P_WIDTH-1:0] refProduct(input int a, input int b);
        longint     full;
        logic [63:0] bits;
        full = longint'(a) * longint'(b);
        bits = full;
        return bits[P_WIDTH-1:0];
    endfunction

    task automatic applyStimulus(input logic rst, input logic [NUM_REQ-1:0] valid, input logic rready);
        ap_rst     = rst;
        req_valid  = valid;
        resp_ready = rready;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_a[k*A_WIDTH +: A_WIDTH] = A_WIDTH'(aVal[k]);
            req_b[k*B_WIDTH +: B_WIDTH] = B_WIDTH'(bVal[k]);
        end
    endtask

    task automatic randomOperands();
        for (int k = 0; k < NUM_REQ; k++) begin
            aVal[k] = int'($urandom_range(0, 16383)) - 8192;
            bVal[k] = int'($urandom_range(0, 511));
        end
    endtask

    task automatic clearModel();
        idQ.delete();
        ageQ.delete();
        pQ.delete();
        ptrM = 0;
    endtask

    // One clock: check outputs mid-cycle against the model, then let the model take the edge.
    task automatic runCycle();
        int                 g;
        logic               expValid;
        logic               advM;
        logic [NUM_REQ-1:0] expReady;
        @(negedge ap_clk);
        expValid = (ageQ.size() > 0) && (ageQ[0] == MUL_STAGES);
        advM     = !expValid || resp_ready;
        g        = -1;
        if (advM && !ap_rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (g < 0 && req_valid[(ptrM + k) % NUM_REQ]) g = (ptrM + k) % NUM_REQ;
            end
        end
        expReady = '0;
        if (g >= 0) expReady[g] = 1'b1;
        sampValid  = resp_valid;
        sampP      = resp_p;
        sampId     = resp_id;
        sampReady  = req_ready;
        sampFlight = in_flight;
        checkOutput("req_ready", 32'(sampReady), 32'(expReady));
        checkOutput("resp_valid", 32'(sampValid), 32'(expValid));
        if (expValid) begin
            checkOutput("resp_p", 32'(sampP), 32'(pQ[0]));
            checkOutput("resp_id", 32'(sampId), 32'(idQ[0]));
        end
        checkOutput("in_flight", 32'(sampFlight), 32'(idQ.size()));
        @(posedge ap_clk);
        if (ap_rst) begin
            clearModel();
        end else if (advM) begin
            if (expValid && resp_ready) begin
                void'(idQ.pop_front());
                void'(ageQ.pop_front());
                void'(pQ.pop_front());
            end
            foreach (ageQ[i]) ageQ[i] = ageQ[i] + 1;
            if (g >= 0) begin
                idQ.push_back(g);
                pQ.push_back(refProduct(aVal[g], bVal[g]));
                ageQ.push_back(1);
                ptrM = (g + 1) % NUM_REQ;
            end
        end
        #1;
    endtask

    initial begin
        for (int k = 0; k < NUM_REQ; k++) begin
            aVal[k] = 0;
            bVal[k] = 0;
        end
        clearModel();
        applyStimulus(1'b1, '1, 1'b1);
        repeat (2) @(posedge ap_clk);
        #1;
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_p", 32'(resp_p), 32'd0);
        checkOutput("rst_resp_id", 32'(resp_id), 32'd0);
        checkOutput("rst_in_flight", 32'(in_flight), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);

        // Single op with exact latency and negative product.
        aVal[0] = -3;
        bVal[0] = 5;
        applyStimulus(1'b0, 4'b0001, 1'b1);
        runCycle();
        checkOutput("t1_grant", 32'(sampReady), 32'd1);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        repeat (MUL_STAGES - 1) runCycle();
        checkOutput("t1_early", 32'(sampValid), 32'd0);
        runCycle();
        checkOutput("t1_valid", 32'(sampValid), 32'd1);
        checkOutput("t1_p", 32'(sampP), 32'h1FFFF1);
        checkOutput("t1_id", 32'(sampId), 32'd0);

        // Wrapping products at the operand extremes.
        aVal[1] = -8192;
        bVal[1] = 511;
        applyStimulus(1'b0, 4'b0010, 1'b1);
        runCycle();
        applyStimulus(1'b0, 4'b0000, 1'b1);
        repeat (MUL_STAGES) runCycle();
        checkOutput("t2_neg_p", 32'(sampP), 32'h002000);
        checkOutput("t2_neg_id", 32'(sampId), 32'd1);
        aVal[2] = 8191;
        bVal[2] = 511;
        applyStimulus(1'b0, 4'b0100, 1'b1);
        runCycle();
        applyStimulus(1'b0, 4'b0000, 1'b1);
        repeat (MUL_STAGES) runCycle();
        checkOutput("t2_pos_p", 32'(sampP), 32'h1FDE01);

        // Fairness with all requesters active.
        applyStimulus(1'b1, 4'b0000, 1'b1);
        runCycle();
        for (int c = 0; c < 6; c++) begin
            randomOperands();
            applyStimulus(1'b0, 4'b1111, 1'b1);
            runCycle();
            grantLog[c] = sampReady;
        end
        checkOutput("t3_g0", 32'(grantLog[0]), 32'h1);
        checkOutput("t3_g1", 32'(grantLog[1]), 32'h2);
        checkOutput("t3_g2", 32'(grantLog[2]), 32'h4);
        checkOutput("t3_g3", 32'(grantLog[3]), 32'h8);
        checkOutput("t3_g4", 32'(grantLog[4]), 32'h1);
        checkOutput("t3_g5", 32'(grantLog[5]), 32'h2);

        // Backpressure with a full pipeline: everything holds.
        applyStimulus(1'b0, 4'b1111, 1'b0);
        runCycle();
        holdP      = sampP;
        holdId     = sampId;
        holdFlight = sampFlight;
        checkOutput("t4_ready0", 32'(sampReady), 32'd0);
        for (int c = 0; c < 2; c++) begin
            runCycle();
            checkOutput("t4_ready", 32'(sampReady), 32'd0);
            checkOutput("t4_p_hold", 32'(sampP), 32'(holdP));
            checkOutput("t4_id_hold", 32'(sampId), 32'(holdId));
            checkOutput("t4_flight_hold", 32'(sampFlight), 32'(holdFlight));
        end
        checkOutput("t4_flight_full", 32'(holdFlight), 32'(MUL_STAGES));
        applyStimulus(1'b0, 4'b1111, 1'b1);
        repeat (3) runCycle();
        applyStimulus(1'b0, 4'b0000, 1'b1);
        repeat (MUL_STAGES + 1) runCycle();

        // Pointer wrap between two active requesters.
        applyStimulus(1'b1, 4'b0000, 1'b1);
        runCycle();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 4'b0011, 1'b1);
            runCycle();
            grantLog[c] = sampReady;
        end
        checkOutput("t5_g2", 32'(grantLog[2]), 32'h1);
        checkOutput("t5_g3", 32'(grantLog[3]), 32'h2);

        // Reset while ops are in flight.
        applyStimulus(1'b1, 4'b0000, 1'b1);
        runCycle();
        applyStimulus(1'b0, 4'b0011, 1'b1);
        repeat (2) runCycle();
        applyStimulus(1'b1, 4'b0000, 1'b1);
        runCycle();
        applyStimulus(1'b0, 4'b0011, 1'b1);
        runCycle();
        checkOutput("t6_valid", 32'(sampValid), 32'd0);
        checkOutput("t6_flight", 32'(sampFlight), 32'd0);
        checkOutput("t6_ptr_grant", 32'(sampReady), 32'h1);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        repeat (MUL_STAGES + 2) runCycle();

        // Random traffic with random backpressure and occasional reset.
        for (int c = 0; c < 400; c++) begin
            randomOperands();
            applyStimulus(($urandom_range(0, 63) == 0), 4'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) != 0));
            runCycle();
        end
        applyStimulus(1'b0, 4'b0000, 1'b1);
        repeat (MUL_STAGES + 2) runCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
